otter_fetch_stage: RTL

- Instruction-fetch stage of the pipelined OTTER core; sits directly upstream of decode.
- Owns the fetch PC and drives the synchronous instruction port of the shared Memory (MEM_ADDR1/MEM_RDEN1/MEM_DOUT1, 1-cycle read latency).
- Delivers a registered {valid, IR, PC, PC+4} bundle to the decode register.
- Handles decode back-pressure with a one-entry skid buffer and squashes wrong-path fetches on execute redirects (taken branch, JAL, JALR).

---
 rtl/otter_fetch_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: OTTER instruction fetch with one-entry skid buffer and redirect squash
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14,
    parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
    input  logic               CPU_CLK,
    input  logic               CPU_RST,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               imem_rden_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_dout_i,
    output logic               de_valid_o,
    output logic [31:0]        de_ir_o,
    output logic [31:0]        de_pc_o,
    output logic [31:0]        de_pc4_o,
    output logic [31:0]        fetch_pc_o
);
    logic        issue;
    logic [31:0] issue_pc;
    logic [31:0] pc_q, pc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_ir_q, skid_ir_d, skid_pc_q, skid_pc_d;
    logic        de_valid_q, de_valid_d;
    logic [31:0] de_ir_q, de_ir_d, de_pc_q, de_pc_d, de_pc4_q, de_pc4_d;
    logic        have_instr;

    // A new read goes out on redirect, when decode is taking, or when nothing is pending
    assign issue       = !CPU_RST && (redirect_i || !stall_i || (!skid_v_q && !inflight_v_q));
    assign issue_pc    = redirect_i ? (redirect_pc_i & ~32'd3) : pc_q;
    assign imem_rden_o = issue;
    assign imem_addr_o = issue_pc[IMEM_AW+1:2];
    assign have_instr  = skid_v_q || inflight_v_q;
    assign de_valid_o  = de_valid_q;
    assign de_ir_o     = de_ir_q;
    assign de_pc_o     = de_pc_q;
    assign de_pc4_o    = de_pc4_q;
    assign fetch_pc_o  = pc_q;

    // Next state: redirect squashes everything, stall parks returning data in the skid slot
    always_comb begin
        pc_d          = issue ? issue_pc + 32'd4 : pc_q;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? issue_pc : inflight_pc_q;
        skid_v_d      = skid_v_q;
        skid_ir_d     = skid_ir_q;
        skid_pc_d     = skid_pc_q;
        de_valid_d    = de_valid_q;
        de_ir_d       = de_ir_q;
        de_pc_d       = de_pc_q;
        de_pc4_d      = de_pc4_q;
        if (redirect_i) begin
            de_valid_d = 1'b0;
            de_ir_d    = NOP_IR;
            skid_v_d   = 1'b0;
        end else if (!stall_i) begin
            skid_v_d   = 1'b0;
            de_valid_d = have_instr;
            de_ir_d    = skid_v_q ? skid_ir_q : inflight_v_q ? imem_dout_i : NOP_IR;
            de_pc_d    = skid_v_q ? skid_pc_q : inflight_v_q ? inflight_pc_q : de_pc_q;
            de_pc4_d   = have_instr ? de_pc_d + 32'd4 : de_pc4_q;
        end else if (inflight_v_q) begin
            skid_v_d  = 1'b1;
            skid_ir_d = imem_dout_i;
            skid_pc_d = inflight_pc_q;
        end
    end

    // State registers, cleared asynchronously so fetch restarts cleanly at RESET_PC
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= 32'd0;
            skid_v_q      <= 1'b0;
            skid_ir_q     <= 32'd0;
            skid_pc_q     <= 32'd0;
            de_valid_q    <= 1'b0;
            de_ir_q       <= NOP_IR;
            de_pc_q       <= 32'd0;
            de_pc4_q      <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            skid_v_q      <= skid_v_d;
            skid_ir_q     <= skid_ir_d;
            skid_pc_q     <= skid_pc_d;
            de_valid_q    <= de_valid_d;
            de_ir_q       <= de_ir_d;
            de_pc_q       <= de_pc_d;
            de_pc4_q      <= de_pc4_d;
        end
    end
endmodule
